// File: rtl/q_signature_analyzer.sv
// Serial MISR compactor for the Q stream of a DFF under test: folds a programmed
// number of valid bits into a CRC-style signature and compares it with a golden value.
`timescale 1ns/1ps
module q_signature_analyzer #(
    parameter int unsigned            SIG_W = 16,
    parameter logic [SIG_W-1:0]       POLY  = 16'h1021,
    parameter logic [SIG_W-1:0]       SEED  = 16'hFFFF,
    parameter int unsigned            LEN_W = 8
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic [SIG_W-1:0] golden,
    input  logic             din,
    input  logic             din_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [LEN_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [SIG_W-1:0]   gold_q, gold_d;
    logic               pass_q, pass_d;

    logic               accept;
    logic               shift;
    logic               last_bit;
    logic               fb;
    logic [SIG_W-1:0]   sig_step;
    logic [LEN_W-1:0]   cnt_inc;

    // One MISR step on the current bit; only committed when a valid bit arrives in RUN.
    always_comb begin
        fb       = sig_q[SIG_W-1] ^ din;
        sig_step = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        cnt_inc  = cnt_q + LEN_W'(1);
        accept   = start && (state_q != S_RUN);
        shift    = (state_q == S_RUN) && din_valid;
        last_bit = shift && (cnt_inc == len_q);
    end

    always_ff @(posedge CK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = (length != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (last_bit) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sig_d  = sig_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        gold_d = gold_q;
        pass_d = pass_q;
        if (accept) begin
            sig_d  = SEED;
            cnt_d  = '0;
            len_d  = length;
            gold_d = golden;
            // A zero-length window finishes immediately on the unmodified seed.
            pass_d = (length == '0) ? (SEED == golden) : 1'b0;
        end else if (shift) begin
            sig_d = sig_step;
            cnt_d = cnt_inc;
            if (last_bit) begin
                pass_d = (sig_step == gold_q);
            end
        end
    end

    always_ff @(posedge CK or negedge RST) begin
        if (!RST) begin
            sig_q  <= SEED;
            cnt_q  <= '0;
            len_q  <= '0;
            gold_q <= '0;
            pass_q <= 1'b0;
        end else begin
            sig_q  <= sig_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            gold_q <= gold_d;
            pass_q <= pass_d;
        end
    end

    always_comb begin
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        pass      = pass_q;
        signature = sig_q;
        bit_count = cnt_q;
    end

endmodule
